// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one 16-bit {rw, addr, wdata} frame per start
// and returns the 8 CIPO bits seen during the data phase in rdata.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  input  logic       CIPO
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be >= 2");
  end
  if (CS_SETUP < 3) begin : g_bad_cs_setup
    $error("spi_controller: CS_SETUP must be >= 3");
  end
  if (CS_HOLD < 2) begin : g_bad_cs_hold
    $error("spi_controller: CS_HOLD must be >= 2");
  end
  if (IDLE_GAP < 3) begin : g_bad_idle_gap
    $error("spi_controller: IDLE_GAP must be >= 3");
  end

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(IDLE_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  bit_cnt;
  logic [14:0] shreg;
  logic [7:0]  cap;

  // bit15 goes straight to COPI on acceptance, so only bits 14:0 are kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cap     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      SCLK    <= 1'b0;
      nCS     <= 1'b1;
      COPI    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= {addr, wdata};
            busy    <= 1'b1;
            nCS     <= 1'b0;
            COPI    <= rw;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          // the edge that ends a high phase both samples CIPO and advances COPI
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!SCLK) begin
              SCLK <= 1'b1;
            end else begin
              SCLK <= 1'b0;
              if (bit_cnt[3]) begin
                cap <= {cap[6:0], CIPO};
              end
              if (bit_cnt == 4'd15) begin
                bit_cnt <= '0;
                state   <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                COPI    <= shreg[14];
                shreg   <= {shreg[13:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            nCS   <= 1'b1;
            COPI  <= 1'b0;
            state <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            rdata <= cap;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a behavioural SPI peripheral with a small register
// file sits on the bus, and a scoreboard checks each frame when done pulses.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       cipo;
  logic       sel = 1'b0;

  logic       busy_a, done_a, sclk_a, ncs_a, copi_a;
  logic [7:0] rdata_a;
  logic       busy_b, done_b, sclk_b, ncs_b, copi_b;
  logic [7:0] rdata_b;

  logic       start_a, start_b;
  logic       busy_m, done_m, sclk_m, ncs_m, copi_m;
  logic [7:0] rdata_m;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign sclk_m  = sel ? sclk_b  : sclk_a;
  assign ncs_m   = sel ? ncs_b   : ncs_a;
  assign copi_m  = sel ? copi_b  : copi_a;
  assign rdata_m = sel ? rdata_b : rdata_a;

  spi_controller dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy_a), .done(done_a), .rdata(rdata_a),
    .SCLK(sclk_a), .nCS(ncs_a), .COPI(copi_a), .CIPO(cipo)
  );

  spi_controller #(.CLK_DIV(2), .CS_SETUP(3), .CS_HOLD(2), .IDLE_GAP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy_b), .done(done_b), .rdata(rdata_b),
    .SCLK(sclk_b), .nCS(ncs_b), .COPI(copi_b), .CIPO(cipo)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc_cnt);
    end
  endtask

  // Timing parameters of whichever instance is selected
  int p_setup, p_div, p_hold, p_period;
  always_comb begin
    p_setup  = sel ? 3 : 4;
    p_div    = sel ? 2 : 4;
    p_hold   = sel ? 2 : 4;
    p_period = p_setup + 32 * p_div + p_hold + (sel ? 3 : 4);
  end

  // Peripheral model: registers 0..4 = en_reg_out_7_0, en_reg_out_15_8,
  // en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
  logic [7:0]  regs [0:4] = '{default: 8'h00};
  logic [15:0] rx_shift = '0;
  logic [15:0] last_frame = '0;
  logic [7:0]  cipo_byte = '0;
  int rises = 0, falls = 0, last_rises = 0;
  int ncs_fall_cyc = 0, ncs_rise_cyc = 0, first_rise_cyc = 0, gap_cyc = 0;

  function automatic logic cipoBit(input int p, input logic [7:0] b);
    if (p >= 8 && p < 16) return b[15 - p];
    return 1'b0;
  endfunction

  initial cipo = 1'b0;

  always @(negedge ncs_m) begin
    gap_cyc      = cyc_cnt - ncs_rise_cyc;
    ncs_fall_cyc = cyc_cnt;
    rises        = 0;
    falls        = 0;
    rx_shift     = '0;
    cipo         = cipoBit(0, cipo_byte);
  end

  always @(posedge sclk_m) begin
    if (ncs_m === 1'b0) begin
      if (rises == 0) first_rise_cyc = cyc_cnt;
      rx_shift = {rx_shift[14:0], copi_m};
      rises++;
    end
  end

  always @(negedge sclk_m) begin
    if (ncs_m === 1'b0) begin
      falls++;
      cipo = cipoBit(falls, cipo_byte);
    end
  end

  always @(posedge ncs_m) begin
    ncs_rise_cyc = cyc_cnt;
    last_frame   = rx_shift;
    last_rises   = rises;
    if (rises == 16 && rx_shift[15] && rx_shift[14:8] < 7'd5)
      regs[rx_shift[10:8]] = rx_shift[7:0];
  end

  // Scoreboard: one entry per accepted frame, checked when done pulses
  typedef struct {
    int          e0;
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (done_m === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("done_cycle",  cyc_cnt,        e.e0 + p_period);
        checkOutput("rdata",       rdata_m,        e.rdata);
        checkOutput("copi_frame",  last_frame,     e.frame);
        checkOutput("sclk_rises",  last_rises,     16);
        checkOutput("ncs_fall",    ncs_fall_cyc,   e.e0);
        checkOutput("first_rise",  first_rise_cyc, e.e0 + p_setup + p_div);
        checkOutput("ncs_rise",    ncs_rise_cyc,   e.e0 + p_setup + 32 * p_div + p_hold);
      end
    end
  end

  // Call at a negedge; start is sampled at the following posedge
  task automatic applyStimulus(input logic r, input logic [6:0] a, input logic [7:0] d,
                               input logic [7:0] cb, input bit expect_done);
    exp_t e;
    rw        = r;
    addr      = a;
    wdata     = d;
    cipo_byte = cb;
    start     = 1'b1;
    if (expect_done) begin
      e.e0    = cyc_cnt + 1;
      e.frame = {r, a, d};
      e.rdata = cb;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy_m, 1);
    checkOutput("ncs_after_start",  ncs_m,  0);
    checkOutput("copi_bit15",       copi_m, r);
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (done_m !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", done_m, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] snap [0:4];
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {ncs_m, sclk_m, copi_m, busy_m, done_m, rdata_m}, 13'h1000);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_after_reset", {ncs_m, sclk_m, copi_m, busy_m, done_m, rdata_m}, 13'h1000);
    end

    $display("[TB] write frame, defaults");
    applyStimulus(1'b1, 7'h04, 8'hA5, 8'h00, 1'b1);
    waitDone(300);
    @(negedge clk);
    checkOutput("done_width", done_m, 0);
    checkOutput("pwm_duty_cycle", regs[4], 8'hA5);

    $display("[TB] read frame with CIPO data");
    snap = regs;
    applyStimulus(1'b0, 7'h01, 8'h00, 8'h3C, 1'b1);
    waitDone(300);
    @(negedge clk);
    for (int i = 0; i < 5; i++) checkOutput("regs_after_read", regs[i], snap[i]);

    $display("[TB] busy rejection and back-to-back");
    applyStimulus(1'b1, 7'h02, 8'h11, 8'h5A, 1'b1);
    repeat (50) @(negedge clk);
    rw = 1'b1; addr = 7'h02; wdata = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(300);
    applyStimulus(1'b1, 7'h00, 8'hFF, 8'hE7, 1'b1);
    checkOutput("done_width_b2b", done_m, 0);
    waitDone(300);
    @(negedge clk);
    checkOutput("en_reg_pwm_7_0", regs[2], 8'h11);
    checkOutput("en_reg_out_7_0", regs[0], 8'hFF);
    checkOutput("ncs_gap", gap_cyc, 5);

    $display("[TB] reset mid-frame");
    snap = regs;
    applyStimulus(1'b1, 7'h03, 8'h99, 8'h00, 1'b0);
    n = 0;
    while (rises < 8 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_8th_rise", rises, 8);
    rst_n = 1'b0;
    #1;
    checkOutput("midframe_reset", {ncs_m, sclk_m, copi_m, busy_m, done_m, rdata_m}, 13'h1000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    for (int i = 0; i < 5; i++) checkOutput("regs_after_abort", regs[i], snap[i]);
    applyStimulus(1'b1, 7'h01, 8'hC3, 8'h81, 1'b1);
    waitDone(300);
    @(negedge clk);
    checkOutput("en_reg_out_15_8", regs[1], 8'hC3);

    $display("[TB] parameter sweep instance");
    sel = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 7'h03, 8'h5A, 8'h66, 1'b1);
    waitDone(200);
    @(negedge clk);
    checkOutput("done_width_sweep", done_m, 0);
    checkOutput("en_reg_pwm_15_8", regs[3], 8'h5A);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
